// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR unit: addresses, funct3 codes,
// mcause values, mstatus bit positions and the address decoder.
package csr_pkg;

  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_RW  = 3'b001;
  localparam logic [2:0] F3_RS  = 3'b010;
  localparam logic [2:0] F3_RC  = 3'b011;
  localparam logic [2:0] F3_RWI = 3'b101;
  localparam logic [2:0] F3_RSI = 3'b110;
  localparam logic [2:0] F3_RCI = 3'b111;

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET = 12'hB02;

  localparam int unsigned MCAUSE_ECALL_M = 11;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  typedef enum logic [2:0] {
    CSR_NONE,
    CSR_MSTATUS,
    CSR_MTVEC,
    CSR_MSCRATCH,
    CSR_MEPC,
    CSR_MCAUSE,
    CSR_MCYCLE,
    CSR_MINSTRET
  } csr_sel_e;

  // Counters decode as unknown when they are not built, so they read 0 and flag illegal.
  function automatic csr_sel_e csr_decode(input logic [11:0] addr, input bit has_counters);
    csr_sel_e sel;
    sel = CSR_NONE;
    case (addr)
      ADDR_MSTATUS:  sel = CSR_MSTATUS;
      ADDR_MTVEC:    sel = CSR_MTVEC;
      ADDR_MSCRATCH: sel = CSR_MSCRATCH;
      ADDR_MEPC:     sel = CSR_MEPC;
      ADDR_MCAUSE:   sel = CSR_MCAUSE;
      ADDR_MCYCLE:   sel = has_counters ? CSR_MCYCLE : CSR_NONE;
      ADDR_MINSTRET: sel = has_counters ? CSR_MINSTRET : CSR_NONE;
      default:       sel = CSR_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/csr_rmw.sv
// Combinational Zicsr read-modify-write: picks the source operand and
// computes the new CSR value plus whether the op has a write side effect.
module csr_rmw
  import csr_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_old,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [4:0]      i_field,
  output logic [XLEN-1:0] o_new,
  output logic            o_write_en
);

  logic [XLEN-1:0] w_src;
  logic            w_field_nz;

  assign w_src      = i_funct3[2] ? {{(XLEN-5){1'b0}}, i_field} : i_rs1_data;
  assign w_field_nz = (i_field != 5'd0);

  // Set/clear with a zero rs1/uimm field is a pure read; write always writes.
  always_comb begin
    o_new      = i_old;
    o_write_en = 1'b0;
    case (i_funct3)
      F3_RW, F3_RWI: begin
        o_new      = w_src;
        o_write_en = 1'b1;
      end
      F3_RS, F3_RSI: begin
        o_new      = i_old | w_src;
        o_write_en = w_field_nz;
      end
      F3_RC, F3_RCI: begin
        o_new      = i_old & ~w_src;
        o_write_en = w_field_nz;
      end
      default: begin
        o_new      = i_old;
        o_write_en = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file with Zicsr datapath, ecall/mret trap sequencing,
// cycle/instret counters and a registered fetch redirect.
module csr_unit
  import csr_pkg::*;
#(
  parameter int          XLEN         = 64,
  parameter logic [63:0] RESET_MTVEC  = 64'h0,
  parameter bit          HAS_COUNTERS = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_inst_valid,
  input  logic [31:0]     i_inst,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_retire,
  input  logic            i_ecall,
  input  logic            i_mret,
  output logic [XLEN-1:0] o_csr_rdata,
  output logic            o_illegal,
  output logic            o_redirect_valid,
  output logic [XLEN-1:0] o_redirect_pc
);

  localparam logic [XLEN-1:0] MTVEC_RST = {RESET_MTVEC[XLEN-1:2], 2'b00};

  logic            r_mie;
  logic            r_mpie;
  logic [XLEN-1:0] r_mtvec;
  logic [XLEN-1:0] r_mscratch;
  logic [XLEN-1:0] r_mepc;
  logic [XLEN-1:0] r_mcause;
  logic [XLEN-1:0] r_mcycle;
  logic [XLEN-1:0] r_minstret;
  logic            r_redirect_valid;
  logic [XLEN-1:0] r_redirect_pc;

  logic [11:0]     w_addr;
  logic [2:0]      w_funct3;
  logic [4:0]      w_field;
  logic            w_csr_op;
  csr_sel_e        w_sel;
  logic            w_known;
  logic [XLEN-1:0] w_mstatus;
  logic [XLEN-1:0] w_old;
  logic [XLEN-1:0] w_new;
  logic            w_we;
  logic            w_ro_viol;
  logic            w_take_ecall;
  logic            w_take_mret;
  logic            w_csr_wr;
  logic            w_unused;

  assign w_addr   = i_inst[31:20];
  assign w_field  = i_inst[19:15];
  assign w_funct3 = i_inst[14:12];
  assign w_unused = ^i_inst[11:7];

  assign w_csr_op = i_inst_valid && (i_inst[6:0] == OPC_SYSTEM) && (w_funct3 != 3'b000);
  assign w_sel    = csr_decode(w_addr, HAS_COUNTERS);
  assign w_known  = (w_sel != CSR_NONE);

  always_comb begin
    w_mstatus               = '0;
    w_mstatus[MSTATUS_MIE]  = r_mie;
    w_mstatus[MSTATUS_MPIE] = r_mpie;
  end

  always_comb begin
    w_old = '0;
    case (w_sel)
      CSR_MSTATUS:  w_old = w_mstatus;
      CSR_MTVEC:    w_old = r_mtvec;
      CSR_MSCRATCH: w_old = r_mscratch;
      CSR_MEPC:     w_old = r_mepc;
      CSR_MCAUSE:   w_old = r_mcause;
      CSR_MCYCLE:   w_old = r_mcycle;
      CSR_MINSTRET: w_old = r_minstret;
      default:      w_old = '0;
    endcase
  end

  csr_rmw #(
    .XLEN (XLEN)
  ) u_rmw (
    .i_funct3   (w_funct3),
    .i_old      (w_old),
    .i_rs1_data (i_rs1_data),
    .i_field    (w_field),
    .o_new      (w_new),
    .o_write_en (w_we)
  );

  assign w_ro_viol    = w_csr_op && w_known && w_we && (w_addr[11:10] == 2'b11);
  assign o_illegal    = w_csr_op && (!w_known || w_ro_viol);
  assign o_csr_rdata  = (w_csr_op && w_known) ? w_old : '0;

  // A trap or trap return in the same cycle suppresses the CSR write entirely.
  assign w_take_ecall = i_inst_valid && i_ecall;
  assign w_take_mret  = i_inst_valid && i_mret && !w_take_ecall;
  assign w_csr_wr     = w_csr_op && w_known && w_we && !w_ro_viol
                        && !w_take_ecall && !w_take_mret;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mie            <= 1'b0;
      r_mpie           <= 1'b0;
      r_mtvec          <= MTVEC_RST;
      r_mscratch       <= '0;
      r_mepc           <= '0;
      r_mcause         <= '0;
      r_mcycle         <= '0;
      r_minstret       <= '0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else begin
      r_redirect_valid <= 1'b0;

      if (w_csr_wr && (w_sel == CSR_MCYCLE)) begin
        r_mcycle <= w_new;
      end else if (HAS_COUNTERS) begin
        r_mcycle <= r_mcycle + 1'b1;
      end

      if (w_csr_wr && (w_sel == CSR_MINSTRET)) begin
        r_minstret <= w_new;
      end else if (HAS_COUNTERS && i_retire) begin
        r_minstret <= r_minstret + 1'b1;
      end

      if (w_take_ecall) begin
        r_mepc           <= {i_pc[XLEN-1:2], 2'b00};
        r_mcause         <= XLEN'(MCAUSE_ECALL_M);
        r_mpie           <= r_mie;
        r_mie            <= 1'b0;
        r_redirect_valid <= 1'b1;
        r_redirect_pc    <= r_mtvec;
      end else if (w_take_mret) begin
        r_mie            <= r_mpie;
        r_mpie           <= 1'b1;
        r_redirect_valid <= 1'b1;
        r_redirect_pc    <= r_mepc;
      end else if (w_csr_wr) begin
        case (w_sel)
          CSR_MSTATUS: begin
            r_mie  <= w_new[MSTATUS_MIE];
            r_mpie <= w_new[MSTATUS_MPIE];
          end
          CSR_MTVEC:    r_mtvec    <= {w_new[XLEN-1:2], 2'b00};
          CSR_MSCRATCH: r_mscratch <= w_new;
          CSR_MEPC:     r_mepc     <= {w_new[XLEN-1:2], 2'b00};
          CSR_MCAUSE:   r_mcause   <= w_new;
          default: ;
        endcase
      end
    end
  end

  assign o_redirect_valid = r_redirect_valid;
  assign o_redirect_pc    = r_redirect_pc;

endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit: CSR ops, trap entry/exit, counters, illegal
// accesses and asynchronous reset in the middle of a trap.
module tb_csr_unit;

  localparam int XLEN = 64;

  logic            clk;
  logic            rst;
  logic            inst_valid;
  logic [31:0]     inst;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] pc;
  logic            retire;
  logic            ecall;
  logic            mret;
  logic [XLEN-1:0] csr_rdata;
  logic            illegal;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  int checks;
  int failures;

  csr_unit #(
    .XLEN         (XLEN),
    .RESET_MTVEC  (64'h80),
    .HAS_COUNTERS (1'b1)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_inst_valid     (inst_valid),
    .i_inst           (inst),
    .i_rs1_data       (rs1_data),
    .i_pc             (pc),
    .i_retire         (retire),
    .i_ecall          (ecall),
    .i_mret           (mret),
    .o_csr_rdata      (csr_rdata),
    .o_illegal        (illegal),
    .o_redirect_valid (redirect_valid),
    .o_redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inst_valid = 1'b0;
    inst       = 32'h0000_0013;
    rs1_data   = '0;
    pc         = '0;
    retire     = 1'b0;
    ecall      = 1'b0;
    mret       = 1'b0;
  endtask

  // rd is fixed at x1 so rd!=0 never matters; rs1/uimm field comes from fld.
  task automatic drive_csr(input logic [2:0] f3, input logic [11:0] addr,
                           input logic [4:0] fld, input logic [63:0] data);
    idle();
    inst_valid = 1'b1;
    inst       = {addr, fld, f3, 5'd1, 7'b1110011};
    rs1_data   = data;
    #1;
  endtask

  task automatic read_csr(input logic [11:0] addr);
    drive_csr(3'b010, addr, 5'd0, 64'h0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    idle();
    rst = 1'b1;
    #1;
    check("reset_redirect_valid", {63'd0, redirect_valid}, 64'd0);
    check("reset_redirect_pc", redirect_pc, 64'd0);
    tick();
    tick();
    rst = 1'b0;

    // 1: reset value of mtvec, set with x0 must not write
    read_csr(12'h305);
    check("mtvec_reset_read", csr_rdata, 64'h80);
    check("mtvec_reset_illegal", {63'd0, illegal}, 64'd0);
    rs1_data = 64'hFFFF;
    #1;
    tick();
    read_csr(12'h305);
    check("mtvec_no_write", csr_rdata, 64'h80);
    read_csr(12'h300);
    check("mstatus_reset", csr_rdata, 64'h0);

    // 2: mscratch rw / rs with zero field / rci / rsi
    drive_csr(3'b001, 12'h340, 5'd2, 64'hDEAD_BEEF);
    check("mscratch_rw_old", csr_rdata, 64'h0);
    tick();
    read_csr(12'h340);
    check("mscratch_rw_new", csr_rdata, 64'hDEAD_BEEF);
    drive_csr(3'b111, 12'h340, 5'h0F, 64'h0);
    check("mscratch_rci_old", csr_rdata, 64'hDEAD_BEEF);
    tick();
    read_csr(12'h340);
    check("mscratch_rci_new", csr_rdata, 64'hDEAD_BEE0);
    drive_csr(3'b011, 12'h340, 5'd0, 64'hFFFF_FFFF);
    tick();
    read_csr(12'h340);
    check("mscratch_rc_x0_nowrite", csr_rdata, 64'hDEAD_BEE0);
    drive_csr(3'b110, 12'h340, 5'h03, 64'h0);
    tick();
    read_csr(12'h340);
    check("mscratch_rsi", csr_rdata, 64'hDEAD_BEE3);
    drive_csr(3'b010, 12'h340, 5'd3, 64'hF000_0000_0000_0000);
    tick();
    read_csr(12'h340);
    check("mscratch_rs", csr_rdata, 64'hF000_0000_DEAD_BEE3);

    // 3: mstatus masking, mtvec low bits, ecall / mret
    drive_csr(3'b001, 12'h300, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    read_csr(12'h300);
    check("mstatus_mask", csr_rdata, 64'h88);
    drive_csr(3'b001, 12'h300, 5'd4, 64'h8);
    tick();
    read_csr(12'h300);
    check("mstatus_mie_only", csr_rdata, 64'h8);
    drive_csr(3'b001, 12'h305, 5'd4, 64'h203);
    tick();
    read_csr(12'h305);
    check("mtvec_low_bits", csr_rdata, 64'h200);

    idle();
    inst_valid = 1'b1;
    inst       = 32'h0000_0073;
    ecall      = 1'b1;
    pc         = 64'h100;
    #1;
    check("ecall_not_csr_rdata", csr_rdata, 64'h0);
    tick();
    idle();
    #1;
    check("ecall_redirect_valid", {63'd0, redirect_valid}, 64'd1);
    check("ecall_redirect_pc", redirect_pc, 64'h200);
    tick();
    check("ecall_redirect_pulse", {63'd0, redirect_valid}, 64'd0);
    read_csr(12'h341);
    check("ecall_mepc", csr_rdata, 64'h100);
    read_csr(12'h342);
    check("ecall_mcause", csr_rdata, 64'd11);
    read_csr(12'h300);
    check("ecall_mstatus", csr_rdata, 64'h80);

    idle();
    inst_valid = 1'b1;
    inst       = 32'h3020_0073;
    mret       = 1'b1;
    #1;
    tick();
    idle();
    #1;
    check("mret_redirect_valid", {63'd0, redirect_valid}, 64'd1);
    check("mret_redirect_pc", redirect_pc, 64'h100);
    read_csr(12'h300);
    check("mret_mstatus", csr_rdata, 64'h88);
    tick();
    check("mret_redirect_pulse", {63'd0, redirect_valid}, 64'd0);

    // 4: illegal addresses, read-only range, counters
    drive_csr(3'b001, 12'h7C0, 5'd4, 64'h1234);
    check("unknown_illegal", {63'd0, illegal}, 64'd1);
    check("unknown_rdata", csr_rdata, 64'h0);
    tick();
    read_csr(12'h340);
    check("unknown_no_side_effect", csr_rdata, 64'hF000_0000_DEAD_BEE3);
    check("known_read_legal", {63'd0, illegal}, 64'd0);
    drive_csr(3'b001, 12'hC00, 5'd4, 64'h1);
    check("ro_range_illegal", {63'd0, illegal}, 64'd1);

    drive_csr(3'b001, 12'hB00, 5'd4, 64'h1000);
    tick();
    read_csr(12'hB00);
    check("mcycle_written", csr_rdata, 64'h1000);
    tick();
    read_csr(12'hB00);
    check("mcycle_increment", csr_rdata, 64'h1001);
    drive_csr(3'b001, 12'hB00, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    read_csr(12'hB00);
    check("mcycle_max", csr_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    read_csr(12'hB00);
    check("mcycle_wrap", csr_rdata, 64'h0);

    drive_csr(3'b001, 12'hB02, 5'd4, 64'h50);
    retire = 1'b1;
    #1;
    tick();
    read_csr(12'hB02);
    retire = 1'b1;
    #1;
    check("minstret_written", csr_rdata, 64'h50);
    tick();
    read_csr(12'hB02);
    check("minstret_retire", csr_rdata, 64'h51);
    tick();
    read_csr(12'hB02);
    check("minstret_hold", csr_rdata, 64'h51);

    // 5: trap beats a same-cycle CSR write; mepc low bits; reset mid-trap
    drive_csr(3'b001, 12'h341, 5'd4, 64'h444);
    ecall = 1'b1;
    pc    = 64'h300;
    #1;
    tick();
    idle();
    #1;
    check("trap_vs_write_redirect", redirect_pc, 64'h200);
    read_csr(12'h341);
    check("trap_vs_write_mepc", csr_rdata, 64'h300);
    drive_csr(3'b001, 12'h341, 5'd4, 64'h107);
    tick();
    read_csr(12'h341);
    check("mepc_low_bits", csr_rdata, 64'h104);

    idle();
    inst_valid = 1'b1;
    inst       = 32'h0000_0073;
    ecall      = 1'b1;
    pc         = 64'h600;
    #1;
    tick();
    idle();
    #1;
    check("midtrap_redirect_valid", {63'd0, redirect_valid}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_redirect_valid", {63'd0, redirect_valid}, 64'd0);
    check("async_rst_redirect_pc", redirect_pc, 64'd0);
    read_csr(12'h305);
    check("async_rst_mtvec", csr_rdata, 64'h80);
    read_csr(12'h340);
    check("async_rst_mscratch", csr_rdata, 64'h0);
    tick();
    rst = 1'b0;
    read_csr(12'h341);
    check("post_rst_mepc", csr_rdata, 64'h0);
    read_csr(12'h342);
    check("post_rst_mcause", csr_rdata, 64'h0);
    read_csr(12'h300);
    check("post_rst_mstatus", csr_rdata, 64'h0);
    read_csr(12'hB00);
    check("post_rst_mcycle", csr_rdata, 64'h0);
    read_csr(12'hB02);
    check("post_rst_minstret", csr_rdata, 64'h0);
    tick();
    check("post_rst_no_redirect", {63'd0, redirect_valid}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
